// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bundle for the scalar lane ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_XOR   = 4'b0010;
  localparam logic [3:0] ALU_SHL   = 4'b0011;
  localparam logic [3:0] ALU_ADD   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0101;
  localparam logic [3:0] ALU_DIV   = 4'b0110;
  localparam logic [3:0] ALU_MUL   = 4'b0111;
  localparam logic [3:0] ALU_SHR   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;
  localparam logic [3:0] ALU_NOTA  = 4'b1011;

  // Condition flags as seen by the flag register and branch unit.
  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } alu_flags_t;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the execute-stage issue logic and one ALU lane.
interface alu_if #(
  parameter int WIDTH = 19
);
  logic             en;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       sel;
  logic [WIDTH-1:0] Out;
  logic             N;
  logic             Z;
  logic             V;
  logic             C;

  // Issue side drives operands and opcode, observes result and flags.
  modport master (
    output en, A, B, sel,
    input  Out, N, Z, V, C
  );

  // ALU side consumes operands and produces the registered result.
  modport slave (
    input  en, A, B, sel,
    output Out, N, Z, V, C
  );
endinterface

// File: rtl/alu_divider.sv
// Combinational unsigned truncating divider; division by zero yields all ones.
module alu_divider #(
  parameter int WIDTH = 19
) (
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic             div_by_zero_o
);

  // Guard the zero divisor so the quotient is well defined in every case.
  always_comb begin
    div_by_zero_o = (divisor_i == '0);
    quotient_o    = '1;
    if (!div_by_zero_o) begin
      quotient_o = dividend_i / divisor_i;
    end
  end

endmodule

// File: rtl/alu_core.sv
// Scalar lane ALU: combinational datapath feeding a result/flag register, 1-cycle latency.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 19
) (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  logic [WIDTH-1:0]   out_q, out_d;
  alu_flags_t         flags_q, flags_d;

  logic [WIDTH:0]     sum_add;
  logic [WIDTH:0]     sum_sub;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic               div_zero;
  logic [4:0]         shamt;

  assign shamt   = bus.B[4:0];
  // Extra top bit captures carry out; subtraction is A + ~B + 1 so carry means no borrow.
  assign sum_add = {1'b0, bus.A} + {1'b0, bus.B};
  assign sum_sub = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, 1'b1};
  assign prod    = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};

  alu_divider #(.WIDTH(WIDTH)) u_div (
    .dividend_i   (bus.A),
    .divisor_i    (bus.B),
    .quotient_o   (quot),
    .div_by_zero_o(div_zero)
  );

  // Opcode mux and per-op V/C; N/Z derive from the selected result for every op.
  always_comb begin
    out_d   = '0;
    flags_d = '0;
    case (bus.sel)
      ALU_AND:   out_d = bus.A & bus.B;
      ALU_OR:    out_d = bus.A | bus.B;
      ALU_XOR:   out_d = bus.A ^ bus.B;
      ALU_SHL:   out_d = bus.A << shamt;
      ALU_SHR:   out_d = bus.A >> shamt;
      ALU_SRA:   out_d = $signed(bus.A) >>> shamt;
      ALU_PASSB: out_d = bus.B;
      ALU_NOTA:  out_d = ~bus.A;
      ALU_ADD: begin
        out_d     = sum_add[WIDTH-1:0];
        flags_d.c = sum_add[WIDTH];
        flags_d.v = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                    (sum_add[WIDTH-1] != bus.A[WIDTH-1]);
      end
      ALU_SUB: begin
        out_d     = sum_sub[WIDTH-1:0];
        flags_d.c = sum_sub[WIDTH];
        flags_d.v = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                    (sum_sub[WIDTH-1] != bus.A[WIDTH-1]);
      end
      ALU_MUL: begin
        out_d     = prod[WIDTH-1:0];
        flags_d.c = |prod[2*WIDTH-1:WIDTH];
      end
      ALU_DIV: begin
        out_d     = quot;
        flags_d.v = div_zero;
      end
      default:   out_d = '0;
    endcase
    flags_d.n = out_d[WIDTH-1];
    flags_d.z = (out_d == '0);
  end

  // Result/flag register; en=0 holds the last captured values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      flags_q <= '0;
    end else if (bus.en) begin
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

  assign bus.Out = out_q;
  assign bus.N   = flags_q.n;
  assign bus.Z   = flags_q.z;
  assign bus.V   = flags_q.v;
  assign bus.C   = flags_q.c;

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core at WIDTH=19; flags checked as {N,Z,V,C}.
module tb_alu_core;
  import alu_pkg::*;

  localparam int W = 19;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  alu_if #(.WIDTH(W)) bus ();

  alu_core #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] exp_out, input logic [3:0] exp_f);
    logic [3:0] got_f;
    got_f = {bus.N, bus.Z, bus.V, bus.C};
    tests_run++;
    assert ({bus.Out, got_f} === {exp_out, exp_f})
    else begin
      tests_failed++;
      $error("FAIL %s: observed Out=%05h NZVC=%b expected Out=%05h NZVC=%b",
             tag, bus.Out, got_f, exp_out, exp_f);
    end
  endtask

  // Drive one operation, clock it in, then look 1 time unit after the edge.
  task automatic op(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                    input string tag, input logic [W-1:0] exp_out, input logic [3:0] exp_f);
    bus.en  = 1'b1;
    bus.sel = s;
    bus.A   = a;
    bus.B   = b;
    @(posedge clk);
    #1;
    $display("[TB] %-10s sel=%b A=%05h B=%05h -> Out=%05h NZVC=%b", tag, s, a, b,
             bus.Out, {bus.N, bus.Z, bus.V, bus.C});
    check(tag, exp_out, exp_f);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n   = 1'b0;
    bus.en  = 1'b0;
    bus.sel = 4'b0000;
    bus.A   = '0;
    bus.B   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 19'h00000, 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    op(ALU_ADD,   19'h00003, 19'h00001, "add_small", 19'h00004, 4'b0000);
    op(ALU_SUB,   19'h00007, 19'h00006, "sub_small", 19'h00001, 4'b0001);
    op(ALU_MUL,   19'h00003, 19'h00002, "mul_small", 19'h00006, 4'b0000);
    op(ALU_DIV,   19'h00004, 19'h00002, "div_small", 19'h00002, 4'b0000);
    op(ALU_ADD,   19'h3FFFF, 19'h00001, "add_ovf",   19'h40000, 4'b1010);
    op(ALU_SUB,   19'h00000, 19'h00001, "sub_borrow",19'h7FFFF, 4'b1000);
    op(ALU_DIV,   19'h00005, 19'h00000, "div_zero",  19'h7FFFF, 4'b1010);
    op(ALU_SUB,   19'h00009, 19'h00009, "sub_eq",    19'h00000, 4'b0101);
    op(ALU_ADD,   19'h7FFFF, 19'h00001, "add_carry", 19'h00000, 4'b0101);
    op(ALU_SUB,   19'h40000, 19'h00001, "sub_ovf",   19'h3FFFF, 4'b0011);
    op(ALU_MUL,   19'h00400, 19'h00400, "mul_hi",    19'h00000, 4'b0101);
    op(ALU_AND,   19'h0F0F0, 19'h0FF00, "and",       19'h0F000, 4'b0000);
    op(ALU_OR,    19'h00F0F, 19'h70000, "or",        19'h70F0F, 4'b1000);
    op(ALU_XOR,   19'h5A5A5, 19'h5A5A5, "xor_zero",  19'h00000, 4'b0100);
    op(ALU_SHL,   19'h00001, 19'h00012, "shl_18",    19'h40000, 4'b1000);
    op(ALU_SHL,   19'h00001, 19'h00013, "shl_19",    19'h00000, 4'b0100);
    op(ALU_SHR,   19'h40000, 19'h00014, "shr_20",    19'h00000, 4'b0100);
    op(ALU_SHR,   19'h40000, 19'h00004, "shr_4",     19'h04000, 4'b0000);
    op(ALU_SRA,   19'h40000, 19'h00004, "sra_4",     19'h7C000, 4'b1000);
    op(ALU_SRA,   19'h40000, 19'h0001F, "sra_31",    19'h7FFFF, 4'b1000);
    op(ALU_SRA,   19'h20000, 19'h00019, "sra_pos",   19'h00000, 4'b0100);
    op(ALU_NOTA,  19'h00000, 19'h12345, "not",       19'h7FFFF, 4'b1000);
    op(4'b1100,   19'h00005, 19'h00005, "rsv_c",     19'h00000, 4'b0100);
    op(4'b1111,   19'h7FFFF, 19'h7FFFF, "rsv_f",     19'h00000, 4'b0100);
    op(ALU_PASSB, 19'h7FFFF, 19'h12345, "pass_b",    19'h12345, 4'b0000);

    // en=0: new operands must not disturb the held result.
    bus.en  = 1'b0;
    bus.sel = ALU_ADD;
    bus.A   = 19'h7FFFF;
    bus.B   = 19'h7FFFF;
    @(posedge clk);
    #1;
    $display("[TB] hold       en=0 -> Out=%05h NZVC=%b", bus.Out, {bus.N, bus.Z, bus.V, bus.C});
    check("hold", 19'h12345, 4'b0000);

    // Capture a flagged result, then assert reset between edges.
    op(ALU_NOTA,  19'h00000, 19'h00000, "pre_rst",   19'h7FFFF, 4'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    $display("[TB] async_rst  -> Out=%05h NZVC=%b", bus.Out, {bus.N, bus.Z, bus.V, bus.C});
    check("async_rst", 19'h00000, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    op(ALU_ADD,   19'h00010, 19'h00020, "post_rst",  19'h00030, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
